binario_bcd: RTL and testbench

//  Sequential binary-to-packed-BCD converter (shift-and-add-3). Feeds the 16-bit
//  'registrador' bus of the 4-digit seven-segment decoder directly downstream.

---
 rtl/binario_bcd_pkg.sv | 16 +
 rtl/binario_bcd_corrige_digito.sv | 15 +
 rtl/binario_bcd.sv | 109 ++++++++++
 tb/tb_binario_bcd.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/binario_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: digit width, blank code
// and FSM state encoding.
package binario_bcd_pkg;

    localparam int unsigned DIGITO_W = 4;

    // Blank code: the downstream seven-segment decoder turns this digit off.
    localparam logic [DIGITO_W-1:0] BCD_APAGADO = 4'hF;

    typedef enum logic [1:0] {
        StOcioso   = 2'd0,
        StConverte = 2'd1,
        StFim      = 2'd2
    } estado_e;

endpackage

// File: rtl/binario_bcd_corrige_digito.sv
// Add-3 correction for one BCD digit.
// Applied before each left shift so that a digit of 5 or more carries into the next digit.
module binario_bcd_corrige_digito
    import binario_bcd_pkg::*;
(
    input  logic [DIGITO_W-1:0] d,
    output logic [DIGITO_W-1:0] q
);

    // Digits 5..9 become 8..12, so doubling them produces a decimal carry.
    always_comb begin
        q = (d >= 4'd5) ? d + 4'd3 : d;
    end

endmodule

// File: rtl/binario_bcd.sv
// Sequential binary-to-packed-BCD converter using shift-and-add-3.
// Each iteration shifts in one bit. The output register changes only when a conversion
// completes, so the display never shows a partial result.
module binario_bcd
    import binario_bcd_pkg::*;
#(
    parameter int unsigned N_BITS    = 14,
    parameter int unsigned N_DIGITOS = 4,
    parameter int unsigned LIMITE    = 9999
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_BITS-1:0]               valor,
    input  logic                            inicio,
    output logic                            ocupado,
    output logic                            pronto,
    output logic                            erro,
    output logic [DIGITO_W*N_DIGITOS-1:0]   registrador
);

    localparam int unsigned ACC_W = DIGITO_W * N_DIGITOS;
    localparam int unsigned CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    estado_e            estado_q, estado_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_BITS-1:0]  shift_q, shift_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   acc_corr;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   reg_q, reg_d;
    logic               erro_q, erro_d;
    logic               pronto_q, pronto_d;

    // One add-3 corrector per BCD digit of the accumulator.
    for (genvar i = 0; i < N_DIGITOS; i++) begin : g_digito
        binario_bcd_corrige_digito u_corrige (
            .d (acc_q[i*DIGITO_W +: DIGITO_W]),
            .q (acc_corr[i*DIGITO_W +: DIGITO_W])
        );
    end

    // Next-state logic: start, one shift per cycle while converting, then publish.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        reg_d    = reg_q;
        erro_d   = erro_q;
        pronto_d = 1'b0;
        unique case (estado_q)
            StOcioso: begin
                if (inicio) begin
                    shift_d  = valor;
                    acc_d    = '0;
                    ovf_d    = 32'(valor) > LIMITE;
                    cnt_d    = CNT_W'(N_BITS - 1);
                    estado_d = StConverte;
                end
            end
            StConverte: begin
                {acc_d, shift_d} = {acc_corr, shift_q} << 1;
                cnt_d            = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    estado_d = StFim;
                end
            end
            StFim: begin
                reg_d    = ovf_q ? {N_DIGITOS{BCD_APAGADO}} : acc_q;
                erro_d   = ovf_q;
                pronto_d = 1'b1;
                estado_d = StOcioso;
            end
            default: begin
                estado_d = StOcioso;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= StOcioso;
            cnt_q    <= '0;
            shift_q  <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            reg_q    <= '0;
            erro_q   <= 1'b0;
            pronto_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            reg_q    <= reg_d;
            erro_q   <= erro_d;
            pronto_q <= pronto_d;
        end
    end

    assign ocupado     = (estado_q != StOcioso);
    assign pronto      = pronto_q;
    assign erro        = erro_q;
    assign registrador = reg_q;

endmodule

// File: tb/tb_binario_bcd.sv
// Self-checking bench for binario_bcd.
// Directed cases cover reset, latency, overflow, ignored starts and back-to-back conversions.
// A randomized sweep is checked against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_binario_bcd;

    logic        clock = 1'b0;
    logic        reset;
    logic [13:0] valor;
    logic        inicio;
    logic        ocupado;
    logic        pronto;
    logic        erro;
    logic [15:0] registrador;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    binario_bcd dut (
        .clock       (clock),
        .reset       (reset),
        .valor       (valor),
        .inicio      (inicio),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .erro        (erro),
        .registrador (registrador)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by division. Overflow shows as all blank digits.
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0] r;
        if (v > 9999) return 16'hFFFF;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs one conversion from an idle DUT and checks latency, busy time, result and the pulse.
    task automatic converte(input int unsigned v, input string tag);
        int n;
        int ocu;
        bit seen;
        n     = 0;
        ocu   = 0;
        seen  = 0;
        valor = 14'(v);
        inicio = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            n++;
            if (n == 1) begin
                inicio = 1'b0;
                valor  = ~valor;  // later changes must not affect the result
            end
            if (ocupado) ocu++;
            if (pronto) seen = 1;
        end
        check_eq({tag, "/pronto_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "/latency"}, 32'(n - 1), 32'd15);
        check_eq({tag, "/ocupado_cycles"}, 32'(ocu), 32'd15);
        check_eq({tag, "/registrador"}, 32'(registrador), 32'(ref_bcd(v)));
        check_eq({tag, "/erro"}, 32'(erro), 32'(v > 9999));
        step();
        check_eq({tag, "/pronto_single"}, 32'(pronto), 32'd0);
        check_eq({tag, "/idle"}, 32'(ocupado), 32'd0);
    endtask

    int unsigned fronteiras [10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};

    initial begin
        int n;
        int t;
        int cnt_pronto;
        int tempos[$];
        bit seen;

        reset  = 1'b1;
        inicio = 1'b0;
        valor  = '0;
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        check_eq("reset/registrador", 32'(registrador), 32'h0000);
        check_eq("reset/ocupado", 32'(ocupado), 32'd0);
        check_eq("reset/pronto", 32'(pronto), 32'd0);
        check_eq("reset/erro", 32'(erro), 32'd0);

        converte(1234, "v1234");
        converte(9999, "v9999");
        converte(0, "v0");
        converte(10000, "v10000");
        repeat (5) step();
        check_eq("hold/erro", 32'(erro), 32'd1);
        check_eq("hold/registrador", 32'(registrador), 32'hFFFF);
        converte(42, "v42");

        // Reset partway through a conversion of 5678.
        valor  = 14'd5678;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        step();
        check_eq("midreset/registrador", 32'(registrador), 32'h0000);
        check_eq("midreset/ocupado", 32'(ocupado), 32'd0);
        check_eq("midreset/pronto", 32'(pronto), 32'd0);
        check_eq("midreset/erro", 32'(erro), 32'd0);
        reset = 1'b0;
        step();
        converte(321, "v321");

        // Start requests during a conversion, including its final cycle, are dropped.
        valor  = 14'd77;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        repeat (5) step();
        valor  = 14'd500;
        inicio = 1'b1;
        seen   = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (pronto) seen = 1;
        end
        inicio = 1'b0;
        check_eq("ignore/pronto_seen", 32'(seen), 32'd1);
        check_eq("ignore/registrador", 32'(registrador), 32'h0077);
        cnt_pronto = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (pronto) cnt_pronto++;
        end
        check_eq("ignore/no_queue", 32'(cnt_pronto), 32'd0);

        // inicio held high: a new conversion is accepted in every first idle cycle.
        valor  = 14'd77;
        inicio = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            if (pronto) tempos.push_back(c);
        end
        inicio = 1'b0;
        check_eq("b2b/count", 32'(tempos.size()), 32'd3);
        if (tempos.size() >= 3) begin
            check_eq("b2b/period1", 32'(tempos[1] - tempos[0]), 32'd16);
            check_eq("b2b/period2", 32'(tempos[2] - tempos[1]), 32'd16);
        end
        check_eq("b2b/registrador", 32'(registrador), 32'h0077);
        repeat (20) step();

        foreach (fronteiras[i]) converte(fronteiras[i], "boundary");

        for (int i = 0; i < 1500; i++) begin
            if (i % 4 == 0) t = int'($urandom_range(16383, 10000));
            else            t = int'($urandom_range(9999, 0));
            converte(t, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
